// File: rtl/serv_bus_timer.sv
// serv_bus_timer: Wishbone-responder RISC-V mtime/mtimecmp timer with a level timer interrupt.
// Define SERV_BUS_TIMER_SHADOW_EN to latch mtime[63:32] on a word-0 read so that a lo/hi read pair is coherent.
module serv_bus_timer #(
  parameter int PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);
  localparam logic [15:0] LAST = 16'(PRESCALE - 1);
  logic [15:0] cnt;
  logic [63:0] mtime, mtimecmp, mtime_nxt, cmp_nxt;
  logic [31:0] mask, cur, merged, hi_rd, rd;
  logic accept, wr, tick;
  assign accept = i_wb_cyc & ~o_wb_ack;
  assign wr     = accept & i_wb_we & |i_wb_sel;
  assign tick   = cnt == LAST;
  assign mask   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  always_comb begin
    cur = i_wb_adr == 2'd0 ? mtime[31:0] :
          i_wb_adr == 2'd1 ? mtime[63:32] :
          i_wb_adr == 2'd2 ? mtimecmp[31:0] : mtimecmp[63:32];
    merged = (cur & ~mask) | (i_wb_dat & mask);
    rd = i_wb_adr == 2'd1 ? hi_rd : cur;
    // a bus write to mtime replaces the increment for that edge
    mtime_nxt = wr && i_wb_adr == 2'd0 ? {mtime[63:32], merged} :
                wr && i_wb_adr == 2'd1 ? {merged, mtime[31:0]} :
                tick ? mtime + 64'd1 : mtime;
    cmp_nxt = wr && i_wb_adr == 2'd2 ? {mtimecmp[63:32], merged} :
              wr && i_wb_adr == 2'd3 ? {merged, mtimecmp[31:0]} : mtimecmp;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      cnt         <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      o_wb_ack    <= 1'b0;
      o_wb_rdt    <= '0;
      o_timer_irq <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + 16'd1;
      mtime       <= mtime_nxt;
      mtimecmp    <= cmp_nxt;
      o_wb_ack    <= accept;
      o_timer_irq <= mtime >= mtimecmp;
      if (accept) o_wb_rdt <= rd;
    end
`ifdef SERV_BUS_TIMER_SHADOW_EN
  logic [31:0] shadow;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) shadow <= '0;
    else if (accept && !i_wb_we && i_wb_adr == 2'd0) shadow <= mtime[63:32];
  assign hi_rd = shadow;
`else
  assign hi_rd = mtime[63:32];
`endif
endmodule
